// File: rtl/hls_deadlock_axis_stall_detector_pkg.sv
// -----------------------------------------------------------------------------
// hls_deadlock_pkg
// Shared types and helpers for the AXI-stream stall detector.
//   stall_state_t  : per-channel stall FSM encoding
//   MAX_CH         : upper bound on monitored channels (index fits in 4 bits)
//   lowest_set_idx : index of the lowest set bit of a MAX_CH vector, 0 if none
// -----------------------------------------------------------------------------
package hls_deadlock_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    BLOCKED = 2'd2
  } stall_state_t;

  function automatic logic [3:0] lowest_set_idx(input logic [MAX_CH-1:0] vec);
    logic [3:0] idx;
    idx = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hls_deadlock_axis_stall_detector_if.sv
// -----------------------------------------------------------------------------
// hls_deadlock_axis_stall_detector_if
// TVALID/TREADY pairs of the AXI-stream ports of one dataflow instance.
//   ch_valid [NUM_CH] : TVALID per stream
//   ch_ready [NUM_CH] : TREADY per stream
// Modports:
//   master : the side presenting the stream handshake (instance / stimulus)
//   slave  : the observer (stall detector), read-only
// -----------------------------------------------------------------------------
interface hls_deadlock_axis_stall_detector_if #(
  parameter int NUM_CH = 3
) ();

  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_ready;

  modport master (output ch_valid, output ch_ready);
  modport slave  (input  ch_valid, input  ch_ready);

endinterface

// File: rtl/hls_deadlock_axis_stall_detector_stall_channel.sv
// -----------------------------------------------------------------------------
// hls_deadlock_stall_channel
// One channel's stall FSM (IDLE -> WAIT -> BLOCKED) with a saturating
// consecutive-wait counter.
// Ports:
//   clock        : rising-edge clock
//   reset        : synchronous, active-high
//   i_wait       : this channel's wait condition for the current cycle
//   i_en         : detection enable; 0 forces the FSM back to IDLE
//   o_block      : registered block flag (state == BLOCKED)
//   o_block_nxt  : next-state blocked flag, for same-cycle aggregate outputs
// -----------------------------------------------------------------------------
module hls_deadlock_stall_channel
  import hls_deadlock_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_wait,
  input  logic i_en,
  output logic o_block,
  output logic o_block_nxt
);

  // Count value seen in WAIT during the TIMEOUT-th consecutive waiting cycle.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

  stall_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_block;
  logic             w_go;

  assign w_go = i_wait & i_en;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_block <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_block <= (w_state_nxt == BLOCKED);
    end
  end

  // NOTE: every output of this block is defaulted first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_go) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!w_go) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_LAST) begin
          // Counter stops here; BLOCKED never increments, so no wrap.
          w_state_nxt = BLOCKED;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      BLOCKED: begin
        if (!w_go) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_block     = r_block;
  assign o_block_nxt = (w_state_nxt == BLOCKED);

endmodule

// File: rtl/hls_deadlock_axis_stall_detector.sv
// -----------------------------------------------------------------------------
// hls_deadlock_axis_stall_detector
// Per-channel AXI-stream block signals for the deadlock idx monitors. A
// channel is flagged once the instance has waited on it for TIMEOUT
// consecutive enabled cycles.
// Ports:
//   clock           : rising-edge clock
//   reset           : synchronous, active-high
//   monitor_en      : 1 = detect, 0 = all channels forced to IDLE
//   axis_if (slave) : ch_valid / ch_ready of each monitored stream
//   axis_block_sigs : registered per-channel block flags
//   any_block       : registered OR of the block flags
//   first_block_idx : lowest blocked channel index (valid with first_block_vld)
//   first_block_vld : a first-blocked index is available
// Build option HLS_DEADLOCK_STICKY_EN: first_block_* capture the first channel
// ever blocked and, with any_block, hold until reset. Without it they track the
// current block set (idx = lowest blocked channel, 0 when none).
// -----------------------------------------------------------------------------
module hls_deadlock_axis_stall_detector
  import hls_deadlock_pkg::*;
#(
  parameter int                NUM_CH        = 3,
  parameter int                TIMEOUT       = 16,
  parameter logic [NUM_CH-1:0] CONSUMER_MASK = NUM_CH'(1),
  parameter int                CNT_W         = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               monitor_en,
  hls_deadlock_axis_stall_detector_if.slave  axis_if,
  output logic [NUM_CH-1:0]                  axis_block_sigs,
  output logic                               any_block,
  output logic [3:0]                         first_block_idx,
  output logic                               first_block_vld
);

  logic [NUM_CH-1:0] w_wait;
  logic [NUM_CH-1:0] w_blk_nxt;
  logic [MAX_CH-1:0] w_blk_nxt_ext;
  logic              w_any_nxt;

  logic              r_any;
  logic              r_vld;
  logic [3:0]        r_idx;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Consumers stall on a missing TVALID, producers on a missing TREADY;
    // a handshake is never a wait in either direction.
    if (CONSUMER_MASK[i]) begin : g_cons
      assign w_wait[i] = axis_if.ch_ready[i] & ~axis_if.ch_valid[i];
    end else begin : g_prod
      assign w_wait[i] = axis_if.ch_valid[i] & ~axis_if.ch_ready[i];
    end

    hls_deadlock_stall_channel #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .i_wait      (w_wait[i]),
      .i_en        (monitor_en),
      .o_block     (axis_block_sigs[i]),
      .o_block_nxt (w_blk_nxt[i])
    );
  end

  assign w_blk_nxt_ext = MAX_CH'(w_blk_nxt);
  assign w_any_nxt     = |w_blk_nxt;

  // Aggregates are built from next-state flags so they register on the same
  // edge as the per-channel block bits.
  // NOTE: reset is synchronous; only control flops exist here, and all of
  // them are reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_any <= 1'b0;
      r_vld <= 1'b0;
      r_idx <= '0;
    end else begin
`ifdef HLS_DEADLOCK_STICKY_EN
      r_any <= r_any | w_any_nxt;
      if (!r_vld && w_any_nxt) begin
        r_vld <= 1'b1;
        r_idx <= lowest_set_idx(w_blk_nxt_ext);
      end
`else
      r_any <= w_any_nxt;
      r_vld <= w_any_nxt;
      r_idx <= lowest_set_idx(w_blk_nxt_ext);
`endif
    end
  end

  assign any_block       = r_any;
  assign first_block_vld = r_vld;
  assign first_block_idx = r_idx;

endmodule

// File: tb/tb_hls_deadlock_axis_stall_detector.sv
// -----------------------------------------------------------------------------
// tb_hls_deadlock_axis_stall_detector
// Directed scenarios followed by random handshake traffic, checked every cycle
// against a run-length reference model of the stall rules.
// -----------------------------------------------------------------------------
module tb_hls_deadlock_axis_stall_detector;

  localparam int          NUM_CH  = 3;
  localparam int          TIMEOUT = 16;
  localparam logic [2:0]  LP_MASK = 3'b001;

  logic              clock;
  logic              reset;
  logic              monitor_en;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              any_block;
  logic [3:0]        first_block_idx;
  logic              first_block_vld;

  hls_deadlock_axis_stall_detector_if #(.NUM_CH(NUM_CH)) axis_if ();

  hls_deadlock_axis_stall_detector #(
    .NUM_CH        (NUM_CH),
    .TIMEOUT       (TIMEOUT),
    .CONSUMER_MASK (LP_MASK),
    .CNT_W         (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .monitor_en      (monitor_en),
    .axis_if         (axis_if),
    .axis_block_sigs (axis_block_sigs),
    .any_block       (any_block),
    .first_block_idx (first_block_idx),
    .first_block_vld (first_block_vld)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: length of the current run of enabled waiting cycles.
  int unsigned       run [NUM_CH];
  logic [NUM_CH-1:0] m_blk;
  logic              m_any;
  logic              m_vld;
  logic [3:0]        m_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [NUM_CH-1:0] v);
    for (int i = 0; i < NUM_CH; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic model_update();
    logic w;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) run[i] = 0;
      m_blk = '0; m_any = 1'b0; m_vld = 1'b0; m_idx = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        w = LP_MASK[i] ? (axis_if.ch_ready[i] && !axis_if.ch_valid[i])
                       : (axis_if.ch_valid[i] && !axis_if.ch_ready[i]);
        if (w && monitor_en) run[i] = (run[i] < TIMEOUT) ? run[i] + 1 : run[i];
        else                 run[i] = 0;
        m_blk[i] = (run[i] >= TIMEOUT);
      end
`ifdef HLS_DEADLOCK_STICKY_EN
      if (!m_vld && (|m_blk)) begin
        m_vld = 1'b1;
        m_idx = lowest(m_blk);
      end
      m_any = m_any | (|m_blk);
`else
      m_any = |m_blk;
      m_vld = m_any;
      m_idx = lowest(m_blk);
`endif
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare all outputs 1 time unit later.
  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
    check("blk", 32'(axis_block_sigs), 32'(m_blk));
    check("any", 32'(any_block),       32'(m_any));
    check("vld", 32'(first_block_vld), 32'(m_vld));
    check("idx", 32'(first_block_idx), 32'(m_idx));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drive(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r);
    axis_if.ch_valid = v;
    axis_if.ch_ready = r;
  endtask

  initial begin
    reset      = 1'b1;
    monitor_en = 1'b1;
    drive(3'b000, 3'b000);
    for (int i = 0; i < NUM_CH; i++) run[i] = 0;
    m_blk = '0; m_any = 1'b0; m_vld = 1'b0; m_idx = '0;

    // Reset state
    ticks(2);
    check("rst_blk", 32'(axis_block_sigs), 32'd0);
    check("rst_vld", 32'(first_block_vld), 32'd0);
    reset = 1'b0;

    // 1: consumer ch0 starved of TVALID
    drive(3'b000, 3'b001);
    ticks(TIMEOUT - 1);
    check("t1_early", 32'(axis_block_sigs), 32'd0);
    tick();
    check("t1_blk", 32'(axis_block_sigs), 32'b001);
    check("t1_any", 32'(any_block), 32'd1);
    ticks(3);
    drive(3'b001, 3'b001);
    tick();
    check("t1_clear", 32'(axis_block_sigs), 32'd0);

    // 2: producer ch1, one handshake restarts the count
    reset = 1'b1; tick(); reset = 1'b0;
    drive(3'b010, 3'b000);
    ticks(TIMEOUT - 1);
    drive(3'b010, 3'b010);
    tick();
    check("t2_hs", 32'(axis_block_sigs), 32'd0);
    drive(3'b010, 3'b000);
    ticks(TIMEOUT - 1);
    check("t2_restart", 32'(axis_block_sigs), 32'd0);
    tick();
    check("t2_blk", 32'(axis_block_sigs), 32'b010);

    // 3: ch1 and ch2 block on the same edge
    reset = 1'b1; tick(); reset = 1'b0;
    drive(3'b110, 3'b000);
    ticks(TIMEOUT);
    check("t3_blk", 32'(axis_block_sigs), 32'b110);
    check("t3_idx", 32'(first_block_idx), 32'd1);

    // 4: continuous handshakes never block
    drive(3'b111, 3'b111);
    ticks(1000);
    check("t4_blk", 32'(axis_block_sigs), 32'd0);

    // 5: reset mid-block discards the count
    reset = 1'b1; tick(); reset = 1'b0;
    drive(3'b000, 3'b001);
    ticks(TIMEOUT);
    check("t5_blk", 32'(axis_block_sigs), 32'b001);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t5_rst_blk", 32'(axis_block_sigs), 32'd0);
    check("t5_rst_any", 32'(any_block), 32'd0);
    check("t5_rst_vld", 32'(first_block_vld), 32'd0);
    ticks(TIMEOUT - 1);
    check("t5_early", 32'(axis_block_sigs), 32'd0);
    tick();
    check("t5_reblk", 32'(axis_block_sigs), 32'b001);

    // monitor_en=0 clears blocks on the next edge
    monitor_en = 1'b0;
    tick();
    check("en_off", 32'(axis_block_sigs), 32'd0);
    monitor_en = 1'b1;
    ticks(TIMEOUT);
    check("en_on", 32'(axis_block_sigs), 32'b001);

    // 6: ch2 blocks then recovers
    reset = 1'b1; tick(); reset = 1'b0;
    drive(3'b100, 3'b000);
    ticks(TIMEOUT);
    check("t6_blk", 32'(axis_block_sigs), 32'b100);
    check("t6_idx", 32'(first_block_idx), 32'd2);
    drive(3'b000, 3'b000);
    tick();
    check("t6_blk_clr", 32'(axis_block_sigs), 32'd0);
`ifdef HLS_DEADLOCK_STICKY_EN
    ticks(5);
    check("t6_vld_hold", 32'(first_block_vld), 32'd1);
    check("t6_idx_hold", 32'(first_block_idx), 32'd2);
    check("t6_any_hold", 32'(any_block), 32'd1);
`else
    check("t6_vld_drop", 32'(first_block_vld), 32'd0);
    check("t6_any_drop", 32'(any_block), 32'd0);
`endif

    // Random traffic: inputs change rarely so long waits occur
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) drive(3'($urandom), 3'($urandom));
      monitor_en = ($urandom_range(0, 31) != 0);
      reset      = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hls_deadlock_axis_stall_detector.md
Name: hls_deadlock_axis_stall_detector

Overview:
Generates the per-channel AXI-stream block signals that the deadlock idx monitors consume on their axis_block_sigs input.
- Watches the valid/ready pair of each AXI-stream port of one dataflow instance (e.g. the AXIvideo2xfMat stage).
- Asserts a channel's block bit once the instance has waited on that stream for TIMEOUT consecutive cycles.
- Sits between the dataflow instance ports and the idx monitor tree.

Parameters:
NUM_CH, 3, number of monitored AXI-stream channels (1..16)
TIMEOUT, 16, consecutive waiting cycles before a channel is declared blocked (2..65535)
CONSUMER_MASK, 3'b001, bit i=1: instance consumes channel i (waits on valid); bit i=0: instance produces channel i (waits on ready)
CNT_W, 16, wait-counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high reset
monitor_en  input  1  1 = detection enabled; 0 = all channels forced to IDLE
ch_valid  input  NUM_CH  TVALID of each monitored stream
ch_ready  input  NUM_CH  TREADY of each monitored stream
axis_block_sigs  output  NUM_CH  per-channel registered block flag, feeds idx monitor
any_block  output  1  registered OR of axis_block_sigs
first_block_idx  output  4  index of the lowest channel that entered BLOCKED (valid while first_block_vld=1)
first_block_vld  output  1  a first-blocked index has been captured

Behaviour:
- Reset (reset=1 at a clock edge): all channel FSMs go to IDLE, counters 0, and all outputs go to 0 (axis_block_sigs, any_block, first_block_idx, first_block_vld).
- Wait condition, per channel i:
  - Consumer (CONSUMER_MASK[i]=1): wait_i = ch_ready[i] & ~ch_valid[i].
  - Producer (CONSUMER_MASK[i]=0): wait_i = ch_valid[i] & ~ch_ready[i].
  - A handshake (valid & ready) is never a wait.
- Per-channel FSM states: IDLE, WAIT, BLOCKED.
  - IDLE: counter = 0. If wait_i & monitor_en, go to WAIT with counter = 1.
  - WAIT: if wait_i & monitor_en, counter increments. When counter == TIMEOUT-1 and wait_i still holds, go to BLOCKED. If wait_i drops, go to IDLE and clear the counter.
  - BLOCKED: stay while wait_i & monitor_en. Otherwise go to IDLE and clear the counter.
- Timing:
  - axis_block_sigs[i] = (state == BLOCKED), registered. It rises on the edge after the TIMEOUT-th consecutive waiting cycle.
  - It falls one cycle after the first non-waiting cycle.
  - any_block follows axis_block_sigs in the same cycle; it is computed from next-state, so it is not delayed by an extra cycle.
- Counter saturates: it never wraps, and is not incremented in BLOCKED.
- monitor_en=0: every FSM goes to IDLE on the next edge and the block bits clear; first_block capture is unaffected.
- Simultaneous entry to BLOCKED on several channels: the lowest index wins the capture.
- A reset asserted mid-wait discards partial counts. Counting restarts from zero after reset deasserts.
- No combinational path from inputs to outputs.

Optional Feature:
Macro HLS_DEADLOCK_STICKY_EN.
- Defined:
  - first_block_idx/first_block_vld capture the first channel to reach BLOCKED.
  - They hold until reset (sticky, for post-mortem debug).
  - any_block is also sticky once set.
- Not defined:
  - first_block_vld = any_block (non-sticky).
  - first_block_idx = the lowest currently blocked index, updated every cycle, 0 when none.

Decomposition:
- Package hls_deadlock_pkg:
  - stall_state_t enum (IDLE=2'd0, WAIT=2'd1, BLOCKED=2'd2).
  - MAX_CH=16.
  - Function lowest_set_idx(vector) returning 4 bits.
- Sub-module hls_deadlock_stall_channel:
  - One FSM plus counter, instantiated NUM_CH times via generate.
  - Takes wait_i and monitor_en; outputs its registered block bit and a next-state blocked flag.
- Top level: wait-condition decode, OR reduction, first-index capture.

Test Plan:
1. NUM_CH=3, TIMEOUT=16, ch0 consumer: hold ready0=1, valid0=0 for 16 cycles -> axis_block_sigs=3'b001 on the edge after cycle 16, any_block=1; assert valid0 at cycle 20 -> bit clears 1 cycle later.
2. Producer ch1: valid1=1, ready1=0 for 15 cycles, then ready1=1 for 1 cycle, then ready1=0 again -> no block asserted; counter restarts; block rises 16 cycles after the restart.
3. ch1 and ch2 both waiting from the same cycle for 16 cycles -> axis_block_sigs=3'b110 together, first_block_idx=1.
4. Continuous handshake on all channels (valid=ready=1) for 1000 cycles -> axis_block_sigs stays 0.
5. ch0 BLOCKED, then reset=1 for 1 cycle -> all outputs 0 the next cycle; with the wait still held, block re-asserts exactly 16 cycles after reset deasserts.
6. With HLS_DEADLOCK_STICKY_EN: ch2 blocks, then ch2 recovers -> first_block_vld=1, idx=2 and any_block=1 persist until reset. Without the macro: both drop 1 cycle after recovery.
